// File: rtl/lab5_pkg.sv
// Shared definitions for the slave_mem write target: widths, depth,
// the slave FSM state type and the 3-bit wrap-around add.
package lab5_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    // S_IDLE  : waiting for a request
    // S_WAIT  : counting down the configured wait cycles
    // S_READY : ready=1, a request present this cycle is committed
    // S_DONE  : absorbs the extra valid cycle held after the handshake
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_DONE  = 2'd3
    } slv_state_t;

    // Accumulate arithmetic: sum in DATA_W bits, carry discarded.
    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/slave_regfile.sv
// 8 x 3 register file: async-reset clear, one write port with enable,
// a combinational peek at the write address (for accumulate) and a
// registered read port that returns the pre-write value on a collision.
module slave_regfile
    import lab5_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] cur_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Current contents of the entry being written, used for accumulate.
    assign cur_data = mem[wr_addr];

    // Storage: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; samples mem before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/slave_mem.sv
// Write-target slave. Handshake: the requester raises in_valid with
// in_addr/in_value stable and keeps it high; a transfer is accepted on
// the rising edge where ready=1 and in_valid=1, and exactly one write is
// committed per request. ready is asserted WAIT cycles after valid is
// first seen and is never high on two consecutive cycles. The FSM state
// is exported on 'state' for observation.
module slave_mem
    import lab5_pkg::*;
#(
    parameter int WAIT  = 2,
    parameter int ACCUM = 0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_value,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [7:0]        wr_count,
    output slv_state_t        state
);

    localparam bit             NO_WAIT   = (WAIT == 0);
    localparam bit             DO_ACCUM  = (ACCUM != 0);
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

    slv_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en;
    logic [DATA_W-1:0] cur_data;
    logic [DATA_W-1:0] wr_data;

    assign state = state_q;

    // Next-state, wait-counter and commit decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (NO_WAIT) begin
                        state_d = S_READY;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!in_valid) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READY: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!in_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Data committed on acceptance: overwrite or 3-bit accumulate.
    always_comb begin
        wr_data = in_value;
        if (DO_ACCUM) begin
            wr_data = add_wrap(cur_data, in_value);
        end
    end

    // State register, wait counter and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready   <= (state_d == S_READY);
        end
    end

    // Count of committed writes, wrapping at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wr_en) begin
            wr_count <= wr_count + 8'd1;
        end
    end

    slave_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (in_addr),
        .wr_data  (wr_data),
        .cur_data (cur_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_slave_mem.sv
// Bench for slave_mem: three instances with different WAIT/ACCUM settings,
// a request-level reference model and a per-cycle compare process.
module tb_slave_mem;
    import lab5_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv   [3];
    logic [2:0] ia   [3];
    logic [2:0] ival [3];
    logic [2:0] ra   [3];
    logic       rdy  [3];
    logic [2:0] rd   [3];
    logic [7:0] wc   [3];
    slv_state_t st   [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state (request level)
    logic [2:0] m_mem  [3][8];
    logic [7:0] m_cnt  [3];
    int         rdy_at [3];
    int         wr_at  [3];
    logic [2:0] wr_a   [3];
    logic [2:0] wr_v   [3];
    logic [2:0] prev_ra[3];

    always #5 clk = ~clk;

    slave_mem #(.WAIT(0), .ACCUM(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_addr(ia[0]), .in_value(ival[0]),
        .ready(rdy[0]), .rd_addr(ra[0]), .rd_data(rd[0]), .wr_count(wc[0]), .state(st[0]));
    slave_mem #(.WAIT(3), .ACCUM(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_addr(ia[1]), .in_value(ival[1]),
        .ready(rdy[1]), .rd_addr(ra[1]), .rd_data(rd[1]), .wr_count(wc[1]), .state(st[1]));
    slave_mem #(.WAIT(2), .ACCUM(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_addr(ia[2]), .in_value(ival[2]),
        .ready(rdy[2]), .rd_addr(ra[2]), .rd_data(rd[2]), .wr_count(wc[2]), .state(st[2]));

    function automatic int wait_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit acc_of(input int k);
        return (k == 2);
    endfunction

    task automatic check(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Compare process: every cycle, every instance
    initial begin
        logic [2:0] exp_rd;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
                    m_cnt[k]  = '0;
                    rdy_at[k] = -1;
                    wr_at[k]  = -1;
                    check("reset_ready", k, rdy[k], 0);
                    check("reset_rd_data", k, rd[k], 0);
                    check("reset_wr_count", k, wc[k], 0);
                end else begin
                    exp_rd = m_mem[k][prev_ra[k]];
                    if (wr_at[k] == cyc) begin
                        if (acc_of(k)) m_mem[k][wr_a[k]] = 3'((m_mem[k][wr_a[k]] + wr_v[k]) % 8);
                        else           m_mem[k][wr_a[k]] = wr_v[k];
                        m_cnt[k] = m_cnt[k] + 8'd1;
                    end
                    check("ready", k, rdy[k], (cyc == rdy_at[k]) ? 1 : 0);
                    check("rd_data", k, rd[k], exp_rd);
                    check("wr_count", k, wc[k], m_cnt[k]);
                end
                prev_ra[k] = ra[k];
            end
        end
    end

    // One request: valid high for 'hold' cycles, then low for 'gap' cycles.
    // Ready is due WAIT+1 cycles after valid rises if valid is still high
    // then; the write lands one cycle later if valid is held into that cycle.
    task automatic do_req(input int k, input logic [2:0] a, input logic [2:0] v,
                          input int hold, input int gap);
        int w;
        int c;
        w = wait_of(k);
        step();
        c = cyc;
        iv[k] = 1'b1; ia[k] = a; ival[k] = v;
        if (hold >= w + 1) rdy_at[k] = c + 1 + w;
        if (hold >= w + 2) begin
            wr_at[k] = c + 2 + w; wr_a[k] = a; wr_v[k] = v;
        end
        repeat (hold) begin
            ra[k] = 3'($urandom_range(0, 7));
            step();
        end
        iv[k] = 1'b0; ia[k] = 3'($urandom_range(0, 7)); ival[k] = 3'($urandom_range(0, 7));
        repeat (gap - 1) step();
    endtask

    task automatic read_lit(input int k, input logic [2:0] a, input string name, input int exp);
        ra[k] = a;
        step();
        step();
        check(name, k, rd[k], exp);
    endtask

    initial begin
        int c;
        int h;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ia[k] = '0; ival[k] = '0; ra[k] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset contents: sweep every read address on every instance
        for (int a = 0; a < 8; a++) begin
            for (int k = 0; k < 3; k++) ra[k] = 3'(a);
            step();
        end
        step();
        check("lit_reset_wr_count", 0, wc[0], 0);
        check("lit_reset_ready", 0, rdy[0], 0);

        // WAIT=0 overwrite, held through handshake as the interconnect does
        do_req(0, 3'd5, 3'd3, 3, 2);
        read_lit(0, 3'd5, "lit_mem5", 3);
        check("lit_wr_count_one", 0, wc[0], 1);

        // WAIT=3: ready exactly 4 cycles after valid, write visible after that
        step();
        c = cyc;
        iv[1] = 1'b1; ia[1] = 3'd3; ival[1] = 3'd7;
        rdy_at[1] = c + 4; wr_at[1] = c + 5; wr_a[1] = 3'd3; wr_v[1] = 3'd7;
        repeat (3) step();
        check("lit_wait3_not_yet", 1, rdy[1], 0);
        step();
        check("lit_wait3_ready", 1, rdy[1], 1);
        step();
        check("lit_wait3_ready_low", 1, rdy[1], 0);
        check("lit_wait3_count", 1, wc[1], 1);
        iv[1] = 1'b0;
        step();

        // Accumulate: 6 then 5 into entry 2 gives 3
        do_req(2, 3'd2, 3'd6, 5, 2);
        do_req(2, 3'd2, 3'd5, 5, 2);
        read_lit(2, 3'd2, "lit_accum_mem2", 3);
        check("lit_accum_count", 2, wc[2], 2);

        // Valid dropped during the wait countdown
        do_req(1, 3'd0, 3'd5, 2, 1);
        step();
        check("lit_drop_state", 1, st[1], S_IDLE);
        check("lit_drop_count", 1, wc[1], 1);

        // Randomized traffic; instance 0 runs long enough to wrap wr_count
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < ((k == 0) ? 400 : 80); n++) begin
                h = ($urandom_range(0, 99) < 80) ? wait_of(k) + 3
                                                  : $urandom_range(1, wait_of(k) + 3);
                do_req(k, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       h, $urandom_range(1, 3));
            end
            step();
        end

        // Reset while in S_READY after entry 1 holds 4
        do_req(0, 3'd1, 3'd4, 3, 2);
        read_lit(0, 3'd1, "lit_pre_reset_mem1", 4);
        step();
        c = cyc;
        iv[0] = 1'b1; ia[0] = 3'd1; ival[0] = 3'd2;
        rdy_at[0] = c + 1; wr_at[0] = c + 2; wr_a[0] = 3'd1; wr_v[0] = 3'd2;
        @(posedge clk);
        #2;
        check("lit_in_ready", 0, rdy[0], 1);
        rst_n = 1'b0;
        #1;
        check("lit_async_ready", 0, rdy[0], 0);
        check("lit_async_count", 0, wc[0], 0);
        iv[0] = 1'b0;
        step();
        rst_n = 1'b1;
        read_lit(0, 3'd1, "lit_post_reset_mem1", 0);
        do_req(0, 3'd1, 3'd2, 3, 2);
        read_lit(0, 3'd1, "lit_after_reset_mem1", 2);
        check("lit_after_reset_count", 0, wc[0], 1);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slave_mem.md
# slave_mem

Write-target slave that sits directly downstream of the two-master/two-slave interconnect; one instance is attached to each slave channel. It accepts a 3-bit address / 3-bit value over a valid/ready handshake, inserts a configurable number of wait cycles before asserting ready, and commits each accepted transfer into an 8-entry × 3-bit register file. A registered read port and a write counter expose its contents to the bench and to later stages.

## Interface
- WAIT, 2: wait cycles inserted between seeing valid and asserting ready; legal range 0..15.
- ACCUM, 0: 0 = overwrite `mem[addr] <= value`; 1 = accumulate `mem[addr] <= mem[addr] + value` (mod 8).
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request from interconnect; held until the cycle after its own registered handshake pulse.
- in_addr  input  3  target entry; valid only while in_valid=1.
- in_value  input  3  write data; valid only while in_valid=1.
- ready  output  1  registered; high only in state S_READY.
- rd_addr  input  3  read address, sampled every cycle.
- rd_data  output  3  registered; `mem[rd_addr]` one cycle after sampling.
- wr_count  output  8  number of committed writes; wraps 255->0.

## Operation
- Reset (asynchronous, any state): state S_IDLE, wait counter 0, ready=0, rd_data=0, wr_count=0, all 8 mem entries 0. Any transfer in flight is dropped and not written.
- S_IDLE: ready=0. If in_valid=1: WAIT=0 -> S_READY; else -> S_WAIT with counter loaded WAIT-1.
- S_WAIT: ready=0. Counter decrements each cycle; at counter=0 -> S_READY. If in_valid drops -> S_IDLE with no write.
- S_READY: ready=1. If in_valid=1, the transfer is accepted: mem updated, wr_count+1, -> S_DONE. If in_valid=0 -> S_IDLE with no write.
- S_DONE: ready=0. Absorbs the extra valid cycle that the interconnect holds after a handshake. Stays until in_valid=0, then -> S_IDLE. No write is ever taken in S_DONE, so one request yields exactly one write.
- Accumulate arithmetic is 3-bit, with carry discarded (e.g. 6+5=3).
- Read port: rd_data <= mem[rd_addr] every cycle. Read and write to the same entry on the same edge returns the old value; the new value appears one cycle later.

## Timing
- in_valid first high in cycle c:
  - ready high in cycle c+1+WAIT.
  - Transfer is sampled at the end of that cycle.
  - mem and wr_count show the new value in cycle c+2+WAIT, with ready low in the same cycle.
- With the interconnect attached and WAIT=0:
  - ready is high in c+1.
  - The interconnect's handshake pulse is high in c+2.
  - in_valid goes low in c+3.
  - The slave returns to S_IDLE in c+4.
  - The earliest next acceptance is in c+5.
- ready is never high for two consecutive cycles.
- At most one write is performed per request.

## Structure
- Shared package `lab5_pkg`:
  - ADDR_W=3, DATA_W=3, DEPTH=8.
  - State enum `slv_state_t` {S_IDLE, S_WAIT, S_READY, S_DONE}.
- One sub-module is natural: `slave_regfile`, an 8×3 array with async-reset clear, a single write port with a write-enable, and a registered read port (read-before-write). slave_mem owns the FSM, the wait counter, accumulate logic and wr_count.

## Test plan
- Reset, then read all 8 addresses -> rd_data=0 for each, wr_count=0, ready=0.
- WAIT=0, ACCUM=0: valid with addr=5, value=3, held through the handshake as the interconnect does -> ready high exactly 1 cycle; mem[5]=3 on read; wr_count=1. The extra valid cycle causes no second write.
- WAIT=3: valid high at cycle 10 -> ready high in cycle 14 only; write visible in cycle 15.
- ACCUM=1: write addr=2 with value=6, then addr=2 with value=5 -> mem[2]=3; wr_count=2.
- Valid dropped during S_WAIT (WAIT=3, valid high only for 2 cycles) -> no ready, no write, state S_IDLE, wr_count unchanged.
- rst_n asserted in S_READY after mem[1]=4 was written -> ready, wr_count and mem[1] all 0 immediately. A subsequent full transfer (addr=1, value=2) then completes normally.
